// File: rtl/fft_sequencer.sv
// Control sequencer for the in-place radix-2 FFT core: bit-reversed load into bank 0,
// log2(N) butterfly stages with ping-pong banks and a delayed write-back, natural-order unload.
module fft_sequencer #(
    parameter int N           = 16,
    parameter int BPU_LATENCY = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(N)-1:0]        io_addr,
    output logic                        load_we,
    output logic [$clog2($clog2(N)):0]  stage_id,
    output logic [$clog2(N)-2:0]        pair_id,
    output logic                        pair_valid,
    output logic                        wb_en,
    output logic                        bank_select,
    output logic                        busy,
    output logic                        done
);

    localparam int LOGN = $clog2(N);
    localparam int SW   = $clog2(LOGN) + 1;
    localparam int PW   = LOGN - 1;
    localparam int DW   = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_UNLOAD  = 2'd3;

    logic [1:0]             state;
    logic [LOGN-1:0]        cnt;
    logic [SW-1:0]          stage_q;
    logic [PW-1:0]          pair_q;
    logic [DW-1:0]          drain_q;
    logic                   draining;
    logic                   done_q;
    logic [BPU_LATENCY-1:0] wb_sr;
    logic [BPU_LATENCY-1:0] wb_next;
    logic                   accept;
    logic                   handshake;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

    // in_ready is gated by reset so it reads 0 while reset is held and 1 right after release
    assign in_ready    = reset && ((state == S_IDLE) || (state == S_LOAD));
    assign accept      = in_valid && in_ready;
    assign load_we     = accept;
    assign out_valid   = (state == S_UNLOAD);
    assign handshake   = out_valid && out_ready;
    assign pair_valid  = (state == S_COMPUTE) && !draining;
    assign wb_en       = wb_sr[BPU_LATENCY-1];
    assign stage_id    = stage_q;
    assign pair_id     = pair_q;
    assign busy        = (state != S_IDLE);
    assign done        = done_q;

    always_comb begin
        wb_next    = wb_sr << 1;
        wb_next[0] = pair_valid;
    end

    always_comb begin
        io_addr = '0;
        case (state)
            S_IDLE, S_LOAD: io_addr = bitrev(cnt);
            S_UNLOAD:       io_addr = cnt;
            default:        io_addr = '0;
        endcase
    end

    // The final results sit in the bank written by the last stage, i.e. bank log2(N) mod 2
    always_comb begin
        bank_select = 1'b0;
        case (state)
            S_COMPUTE: bank_select = stage_q[0];
            S_UNLOAD:  bank_select = 1'(LOGN % 2);
            default:   bank_select = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            stage_q  <= '0;
            pair_q   <= '0;
            drain_q  <= '0;
            draining <= 1'b0;
            done_q   <= 1'b0;
            wb_sr    <= '0;
        end else begin
            done_q <= 1'b0;
            wb_sr  <= wb_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt   <= LOGN'(1);
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (cnt == LOGN'(N - 1)) begin
                            state    <= S_COMPUTE;
                            cnt      <= '0;
                            stage_q  <= '0;
                            pair_q   <= '0;
                            drain_q  <= '0;
                            draining <= 1'b0;
                        end else begin
                            cnt <= cnt + LOGN'(1);
                        end
                    end
                end
                // Issue N/2 pairs back to back, then idle BPU_LATENCY cycles so the stage's writes land
                S_COMPUTE: begin
                    if (!draining) begin
                        if (pair_q == PW'(N / 2 - 1)) begin
                            draining <= 1'b1;
                            drain_q  <= '0;
                        end else begin
                            pair_q <= pair_q + PW'(1);
                        end
                    end else if (drain_q == DW'(BPU_LATENCY - 1)) begin
                        draining <= 1'b0;
                        drain_q  <= '0;
                        pair_q   <= '0;
                        if (stage_q == SW'(LOGN - 1)) begin
                            state   <= S_UNLOAD;
                            cnt     <= '0;
                            stage_q <= '0;
                        end else begin
                            stage_q <= stage_q + SW'(1);
                        end
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                S_UNLOAD: begin
                    if (handshake) begin
                        if (cnt == LOGN'(N - 1)) begin
                            state  <= S_IDLE;
                            cnt    <= '0;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt + LOGN'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer (N=16, BPU_LATENCY=3) with hand-computed expectations.
module tb_fft_sequencer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] io_addr;
    logic       load_we;
    logic [2:0] stage_id;
    logic [2:0] pair_id;
    logic       pair_valid;
    logic       wb_en;
    logic       bank_select;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int brev_table [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    logic [3:0] toggle_pat = 4'b1001;

    fft_sequencer #(.N(16), .BPU_LATENCY(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .io_addr(io_addr),
        .load_we(load_we), .stage_id(stage_id), .pair_id(pair_id),
        .pair_valid(pair_valid), .wb_en(wb_en), .bank_select(bank_select),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; checks run 1ns later, well away from the rising edge
    task automatic applyStimulus(input logic v, input logic r);
        @(negedge clk);
        in_valid  = v;
        out_ready = r;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hs;
        int cyc;
        int writes;
        int p;
        logic exp_pv;
        logic exp_wb;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);

        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_load_we", load_we, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_pair_valid", pair_valid, 0);
        checkOutput("rst_wb_en", wb_en, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_io_addr", io_addr, 0);
        reset = 1'b1;
        #1;

        // Run 1: continuous load, full compute, unload with out_ready held high
        for (int i = 0; i < 16; i++) begin
            if (i > 0) applyStimulus(1'b1, 1'b0);
            checkOutput("load_in_ready", in_ready, 1);
            checkOutput("load_we", load_we, 1);
            checkOutput("load_addr", io_addr, brev_table[i]);
        end
        for (int k = 0; k < 44; k++) begin
            applyStimulus(1'b0, 1'b1);
            p = k % 11;
            exp_pv = (p < 8);
            exp_wb = (k >= 3) && (((k - 3) % 11) < 8);
            if (k == 0) checkOutput("compute_in_ready", in_ready, 0);
            checkOutput("cmp_pair_valid", pair_valid, exp_pv);
            checkOutput("cmp_stage_id", stage_id, k / 11);
            checkOutput("cmp_bank", bank_select, (k / 11) % 2);
            checkOutput("cmp_wb_en", wb_en, exp_wb);
            checkOutput("cmp_busy", busy, 1);
            if (exp_pv) checkOutput("cmp_pair_id", pair_id, p);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("unl_out_valid", out_valid, 1);
            checkOutput("unl_addr", io_addr, i);
            checkOutput("unl_bank", bank_select, 0);
            checkOutput("unl_done", done, 0);
            checkOutput("unl_wb_en", wb_en, 0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("done_pulse", done, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_out_valid", out_valid, 0);
        checkOutput("done_in_ready", in_ready, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("done_single", done, 0);

        // Run 2: unload with out_ready pattern 1,0,0,1; a sample is offered in the done cycle
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < 44; k++) applyStimulus(1'b0, 1'b0);
        hs = 0;
        cyc = 0;
        while (cyc < 100) begin
            applyStimulus(1'b0, toggle_pat[cyc % 4]);
            if (!out_valid) break;
            checkOutput("tog_addr", io_addr, hs);
            if (out_ready) hs++;
            cyc++;
        end
        checkOutput("tog_not_timeout", (cyc < 100), 1);
        checkOutput("tog_handshakes", hs, 16);
        checkOutput("tog_done", done, 1);
        in_valid = 1'b1;
        #1;
        checkOutput("done_cycle_accept", load_we, 1);
        checkOutput("done_cycle_addr", io_addr, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_done_busy", busy, 1);
        checkOutput("post_done_pulse", done, 0);

        // Run 3: reset out of LOAD, gapped load, then reset mid-compute
        reset = 1'b0;
        #1;
        checkOutput("rst2_busy", busy, 0);
        checkOutput("rst2_in_ready", in_ready, 0);
        applyStimulus(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("rel2_in_ready", in_ready, 1);
        writes = 0;
        for (int c = 0; c < 31; c++) begin
            applyStimulus((c % 2) == 0, 1'b0);
            checkOutput("gap_in_ready", in_ready, 1);
            checkOutput("gap_pair_valid", pair_valid, 0);
            if ((c % 2) == 0) begin
                checkOutput("gap_we", load_we, 1);
                checkOutput("gap_addr", io_addr, brev_table[c / 2]);
            end else begin
                checkOutput("gap_we_idle", load_we, 0);
            end
            if (load_we) writes++;
        end
        checkOutput("gap_writes", writes, 16);
        applyStimulus(1'b0, 1'b0);
        checkOutput("gap_compute_entry", pair_valid, 1);
        checkOutput("gap_in_ready_low", in_ready, 0);
        repeat (27) applyStimulus(1'b0, 1'b0);
        checkOutput("mid_stage", stage_id, 2);
        checkOutput("mid_pair", pair_id, 5);
        checkOutput("mid_pair_valid", pair_valid, 1);
        reset = 1'b0;
        #1;
        checkOutput("async_pair_valid", pair_valid, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_stage", stage_id, 0);
        checkOutput("async_pair", pair_id, 0);
        checkOutput("async_wb_en", wb_en, 0);
        checkOutput("async_in_ready", in_ready, 0);
        checkOutput("async_bank", bank_select, 0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("rel3_in_ready", in_ready, 1);
        checkOutput("rel3_busy", busy, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("rel3_wb_en", wb_en, 0);
            checkOutput("rel3_pair_valid", pair_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Control FSM for the in-place radix-2 FFT core.
- Accepts N time-domain samples over a valid/ready stream and writes them bit-reversed into RAM bank 0.
- Sequences log2(N) butterfly stages by issuing (stage_id, pair_id) to the AGU and generating ping-pong bank selection plus delayed write-back enables that match the BPU pipeline.
- Streams the N results out in natural order over a valid/ready handshake.

Parameters:
- N, 16: transform length; power of two, 4 to 1024.
- BPU_LATENCY, 3: cycles from pair issue (pair_valid) to butterfly result ready for write-back; range 1 to 8.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  sequencer accepts a sample this cycle.
- out_valid  out  1  result at io_addr is valid on the RAM async read port.
- out_ready  in  1  downstream accepts the result.
- io_addr  out  log2(N)  load write address (bit-reversed) or unload read address (natural order).
- load_we  out  1  write enable for the load sample into bank 0.
- stage_id  out  clog2(log2(N))+1  current butterfly stage to the AGU.
- pair_id  out  log2(N)-1  current butterfly pair to the AGU.
- pair_valid  out  1  stage_id/pair_id are a real issue this cycle.
- wb_en  out  1  write-back enable for butterfly results (C,D).
- bank_select  out  1  read bank; the write bank is its complement.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset, asserted at any time including mid-operation:
  - state=IDLE; all counters 0; every output 0.
  - in_ready is 0 while reset is held and 1 in the first cycle after release.
  - The pipeline delay line for wb_en is cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready: load_we=1, io_addr=bitrev(0), cnt<=1, next state LOAD.
  - LOAD: in_ready=1; io_addr=bitrev(cnt); load_we=in_valid.
    - Each accept increments cnt.
    - The accept with cnt==N-1 moves to COMPUTE with stage_id=0, pair_id=0, cnt=0.
    - in_valid low holds all state.
  - COMPUTE, ISSUE sub-phase: pair_valid=1 for each cycle; pair_id counts 0..N/2-1, one per cycle, no stalls.
  - COMPUTE, DRAIN sub-phase: after pair N/2-1, pair_valid=0 for exactly BPU_LATENCY cycles so all writes of the stage land before the next stage reads.
    - Then stage_id increments and pair_id resets to 0.
    - After DRAIN of stage log2(N)-1, move to UNLOAD with cnt=0.
  - UNLOAD: out_valid=1; io_addr=cnt.
    - On out_valid&out_ready, cnt increments.
    - Handshake at cnt==N-1: done=1 next cycle, state IDLE, counters 0.
    - out_ready low holds io_addr and out_valid.
- in_ready=0 in COMPUTE and UNLOAD; in_valid is ignored there and nothing is written.
- Write-back: wb_en is pair_valid delayed by exactly BPU_LATENCY cycles through a shift register.
- Bank selection:
  - LOAD/IDLE: bank_select=0. The load writes bank 0 directly and ignores the complement-bank rule.
  - COMPUTE: bank_select=stage_id[0], registered with stage_id so it changes in the same cycle.
  - UNLOAD: bank_select=log2(N) mod 2, the bank holding the final results.
- Timing and arithmetic:
  - Compute latency per stage = N/2 + BPU_LATENCY cycles.
  - Total COMPUTE = log2(N)*(N/2+BPU_LATENCY) cycles.
  - Bit reversal is over log2(N) bits.
  - Counters wrap only via explicit reset to 0; no modular overflow is relied on.
- Simultaneous events: done pulses in the cycle after the final handshake, coinciding with IDLE. A sample offered in that same cycle is accepted (in_ready=1 in IDLE).

Test Plan:
- Reset release, N=16: in_valid=1 for 16 cycles with samples 0..15 -> load_we high 16 cycles; io_addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; in_ready drops after the 16th accept.
- COMPUTE, N=16, BPU_LATENCY=3:
  - pair_valid high 8 cycles, then low 3, repeated for stage_id 0..3.
  - Total COMPUTE = 44 cycles.
  - wb_en equals pair_valid shifted by 3.
  - bank_select = 0,1,0,1 per stage.
- UNLOAD with out_ready=1: io_addr 0..15 on consecutive cycles; bank_select=0; done pulses once; busy falls with done.
- out_ready toggled 1,0,0,1 during UNLOAD: io_addr holds during the low cycles and advances only on handshakes; 16 handshakes in total.
- in_valid gaps during LOAD (valid every other cycle): exactly 16 writes, correct bit-reversed addresses, no COMPUTE entry before the 16th accept.
- reset asserted mid-COMPUTE at stage_id=2, pair_id=5: outputs are 0 asynchronously; after release the state is IDLE, in_ready=1, and no wb_en pulse emerges from the cleared delay line.
